// File: rtl/pe_noc_endpoint.sv
// NoC processing-element endpoint: buffers incoming flits, adds 1 to every 32-bit payload lane, returns result to the scheduler.
// Optional macro PE_DEST_CHECK_EN: drop and count flits not addressed to (MY_X, MY_Y).
`ifndef PE_X_SIZE
`define PE_X_SIZE 4
`endif
`ifndef PE_Y_SIZE
`define PE_Y_SIZE 4
`endif
`ifndef PE_PCK_NUM
`define PE_PCK_NUM 8
`endif

module pe_noc_endpoint #(
    parameter int unsigned DATA_W         = 256,
    parameter int unsigned X_SIZE         = `PE_X_SIZE,
    parameter int unsigned Y_SIZE         = `PE_Y_SIZE,
    parameter int unsigned PCK_NUM        = `PE_PCK_NUM,
    parameter int unsigned MY_X           = 0,
    parameter int unsigned MY_Y           = 1,
    parameter int unsigned SCHED_X        = 0,
    parameter int unsigned SCHED_Y        = 0,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned COMPUTE_CYCLES = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      i_valid,
    input  logic [DATA_W+PCK_NUM+Y_SIZE+X_SIZE-1:0]   i_data,
    output logic                                      o_ready,
    output logic                                      o_valid,
    output logic [DATA_W+PCK_NUM+Y_SIZE+X_SIZE-1:0]   o_data,
    input  logic                                      i_ready,
    output logic                                      o_busy,
    output logic [7:0]                                o_drop_cnt
);

    localparam int unsigned TW    = DATA_W + PCK_NUM + Y_SIZE + X_SIZE;
    localparam int unsigned EW    = DATA_W + PCK_NUM;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned KW    = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
    localparam int unsigned LANES = DATA_W / 32;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, SEND} state_e;

    state_e             state_q, state_d;
    logic [EW-1:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic               ready_q, busy_q;
    logic               valid_q, valid_d;
    logic [TW-1:0]      data_q, data_d;
    logic [KW-1:0]      cyc_q, cyc_d;
    logic [DATA_W-1:0]  pay_q, pay_d, result_c;
    logic [PCK_NUM-1:0] pck_q, pck_d;
    logic [7:0]         drop_q;
    logic               accept_c, push_c, pop_c;

    assign accept_c = i_valid && ready_q;

`ifdef PE_DEST_CHECK_EN
    logic dest_ok_c;
    assign dest_ok_c = (i_data[Y_SIZE+X_SIZE-1:0] == {Y_SIZE'(MY_Y), X_SIZE'(MY_X)});
    assign push_c    = accept_c && dest_ok_c;

    // Misaddressed flits are consumed but only counted, saturating at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
        end else if (accept_c && !dest_ok_c && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end
`else
    logic unused_dest;
    assign unused_dest = ^{i_data[Y_SIZE+X_SIZE-1:0], Y_SIZE'(MY_Y), X_SIZE'(MY_X)};
    assign push_c      = accept_c;
    assign drop_q      = 8'd0;
`endif

    always_comb begin
        count_d = count_q;
        if (push_c && !pop_c) begin
            count_d = count_q + CW'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO control; ready and busy are registered views of the post-edge state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ready_q <= (count_d != CW'(FIFO_DEPTH));
            busy_q  <= (state_d != IDLE) || (count_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= i_data[TW-1:Y_SIZE+X_SIZE];
    end

    // Per-lane increment, no carry between lanes
    always_comb begin
        result_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            result_c[i*32 +: 32] = pay_q[i*32 +: 32] + 32'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        pay_d   = pay_q;
        pck_d   = pck_q;
        valid_d = valid_q;
        data_d  = data_q;
        pop_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = LOAD;
            end
            LOAD: begin
                pop_c          = 1'b1;
                {pay_d, pck_d} = mem_q[rd_ptr_q];
                cyc_d          = KW'(COMPUTE_CYCLES - 1);
                state_d        = COMPUTE;
            end
            COMPUTE: begin
                if (cyc_q == '0) begin
                    state_d = SEND;
                    valid_d = 1'b1;
                    data_d  = {result_c, pck_q, Y_SIZE'(SCHED_Y), X_SIZE'(SCHED_X)};
                end else begin
                    cyc_d = cyc_q - KW'(1);
                end
            end
            SEND: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    data_d  = '0;
                    state_d = (count_q != '0) ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            pay_q   <= '0;
            pck_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            pay_q   <= pay_d;
            pck_q   <= pck_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_busy     = busy_q;
    assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_pe_noc_endpoint.sv
// Directed self-checking bench for pe_noc_endpoint (256-bit payload, 4/4/8-bit x/y/pck fields).
module tb_pe_noc_endpoint;

    localparam int unsigned TW = 272;

    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic [TW-1:0] i_data;
    logic          o_ready;
    logic          o_valid;
    logic [TW-1:0] o_data;
    logic          i_ready;
    logic          o_busy;
    logic [7:0]    o_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pe_noc_endpoint #(
        .DATA_W(256), .X_SIZE(4), .Y_SIZE(4), .PCK_NUM(8),
        .MY_X(0), .MY_Y(1), .SCHED_X(0), .SCHED_Y(0),
        .FIFO_DEPTH(4), .COMPUTE_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
        .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
        .o_busy(o_busy), .o_drop_cnt(o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_pay(input int unsigned k, input int unsigned add);
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = 32'(k * 256 + j + add);
        return r;
    endfunction

    function automatic logic [TW-1:0] flit(input logic [255:0] p, input int unsigned pck,
                                            input int unsigned y, input int unsigned x);
        return {p, 8'(pck), 4'(y), 4'(x)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_flit(input logic [TW-1:0] f);
        int n = 0;
        while (!o_ready && n < 100) begin
            tick();
            n++;
        end
        if (!o_ready) check("send_timeout", TW'(o_ready), TW'(1));
        i_valid = 1'b1;
        i_data  = f;
        tick();
        i_valid = 1'b0;
        i_data  = '0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!o_valid && n < 100) begin
            tick();
            n++;
        end
        if (!o_valid) check(tag, TW'(o_valid), TW'(1));
    endtask

    task automatic handshake();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic consume(input string tag, input logic [TW-1:0] exp);
        wait_valid(tag);
        check(tag, o_data, exp);
        handshake();
    endtask

    initial begin
        logic [255:0]  p;
        logic [255:0]  e;
        logic [TW-1:0] exp0;
        logic          seen;

        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_ready = 1'b0;

        // Reset values
        #12;
        check("rst_ready", TW'(o_ready), TW'(0));
        check("rst_valid", TW'(o_valid), TW'(0));
        check("rst_busy",  TW'(o_busy),  TW'(0));
        check("rst_drop",  TW'(o_drop_cnt), TW'(0));
        check("rst_data",  o_data, '0);
        tick();
        rst_n = 1'b1;
        check("ready_before_edge", TW'(o_ready), TW'(0));
        tick();
        check("ready_after_edge", TW'(o_ready), TW'(1));

        // Single flit latency and result
        send_flit(flit(mk_pay(0, 1), 5, 1, 0));
        repeat (5) tick();
        check("lat_not_yet", TW'(o_valid), TW'(0));
        tick();
        check("lat_valid", TW'(o_valid), TW'(1));
        check("single_data", o_data, flit(mk_pay(0, 2), 5, 0, 0));
        handshake();
        check("single_valid_drop", TW'(o_valid), TW'(0));
        check("single_idle", TW'(o_busy), TW'(0));

        // Lane wrap-around
        p = mk_pay(0, 0) & '0;
        p[31:0]  = 32'h7FFF_FFFF;
        p[63:32] = 32'hFFFF_FFFF;
        p[95:64] = 32'h1234_5678;
        e = '0;
        e[31:0]  = 32'h8000_0000;
        e[63:32] = 32'h0000_0000;
        e[95:64] = 32'h1234_5679;
        for (int j = 3; j < 8; j++) e[j*32 +: 32] = 32'd1;
        send_flit(flit(p, 3, 1, 0));
        consume("wrap_data", flit(e, 3, 0, 0));

        // Backpressure: stalled SEND, four more flits buffered
        exp0 = flit(mk_pay(16, 1), 0, 0, 0);
        send_flit(flit(mk_pay(16, 0), 0, 1, 0));
        wait_valid("bp_valid");
        check("bp_data0", o_data, exp0);
        for (int k = 1; k <= 4; k++) send_flit(flit(mk_pay(16 + k, 0), k, 1, 0));
        check("bp_full_ready", TW'(o_ready), TW'(0));
        for (int c = 0; c < 6; c++) begin
            tick();
            check("bp_hold_valid", TW'(o_valid), TW'(1));
            check("bp_hold_data", o_data, exp0);
        end
        handshake();
        for (int k = 1; k <= 4; k++) consume("bp_order", flit(mk_pay(16 + k, 1), k, 0, 0));
        repeat (3) tick();
        check("bp_drained", TW'(o_busy), TW'(0));

        // Reset mid-COMPUTE with two flits queued
        send_flit(flit(mk_pay(32, 0), 20, 1, 0));
        send_flit(flit(mk_pay(33, 0), 21, 1, 0));
        send_flit(flit(mk_pay(34, 0), 22, 1, 0));
        tick();
        check("pre_rst_busy", TW'(o_busy), TW'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", TW'(o_valid), TW'(0));
        check("mid_rst_busy",  TW'(o_busy),  TW'(0));
        check("mid_rst_ready", TW'(o_ready), TW'(0));
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            seen = seen | o_valid;
        end
        check("post_rst_silent", TW'(seen), TW'(0));
        check("post_rst_busy", TW'(o_busy), TW'(0));

        // Destination check
        for (int k = 6; k <= 8; k++) send_flit(flit(mk_pay(k, 0), k, 1, 1));
        send_flit(flit(mk_pay(9, 0), 9, 1, 0));
`ifdef PE_DEST_CHECK_EN
        consume("dest_only", flit(mk_pay(9, 1), 9, 0, 0));
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            seen = seen | o_valid;
        end
        check("dest_no_extra", TW'(seen), TW'(0));
        check("dest_drop_cnt", TW'(o_drop_cnt), TW'(3));
`else
        for (int k = 6; k <= 9; k++) consume("dest_all", flit(mk_pay(k, 1), k, 0, 0));
        check("dest_drop_cnt", TW'(o_drop_cnt), TW'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
